// File: rtl/float_pkg.sv
// Shared float format definitions: default field widths, exponent bias, converter FSM states.
// Latency: n/a (package).
// Backpressure: n/a (package).
package float_pkg;

  // Default operand format (IEEE single precision layout)
  localparam int DEF_EXPONENT_WIDTH = 8;
  localparam int DEF_MANTISSA_WIDTH = 23;

  // Exponent bias for a given exponent field width: 2^(ew-1)-1
  function automatic int float_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Converter control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } cvt_state_t;

endpackage

// File: rtl/float_round.sv
// Round-to-nearest-even of a truncated fraction given its guard and sticky bits.
// Latency: combinational.
// Backpressure: none (pure function).
module float_round #(
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic [MANTISSA_WIDTH-1:0] frac_in,
  input  logic                      guard,
  input  logic                      sticky,
  output logic [MANTISSA_WIDTH-1:0] frac_out,
  output logic                      carry
);

  logic round_up;

  // Round up above the halfway point, or exactly at it when the kept lsb is odd
  always_comb begin
    round_up          = guard & (sticky | frac_in[0]);
    {carry, frac_out} = {1'b0, frac_in} + {{MANTISSA_WIDTH{1'b0}}, round_up};
  end

endmodule

// File: rtl/int_to_float.sv
// Signed integer to {sign, exponent, mantissa} float, normalising one bit per cycle.
// Latency: k+2 edges after accept (k = leading zeros of |in_int|), 0 extra edges for zero input.
// Backpressure: single result held in DONE until out_ready; in_ready only while IDLE.
module int_to_float
  import float_pkg::*;
#(
  parameter int EXPONENT_WIDTH = DEF_EXPONENT_WIDTH,
  parameter int MANTISSA_WIDTH = DEF_MANTISSA_WIDTH,
  // INT_WIDTH-1 must not exceed the exponent bias, so the result can never overflow
  parameter int INT_WIDTH      = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [INT_WIDTH-1:0]                     in_int,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   out_float
);

  localparam int BIAS = float_bias(EXPONENT_WIDTH);
  localparam int CW   = (INT_WIDTH > 2) ? $clog2(INT_WIDTH) : 1;
  // Bits below the hidden one, followed by enough zeros that guard and
  // sticky always exist; when the integer fits in the fraction they stay zero
  // and the rounder becomes a no-op.
  localparam int PW   = (INT_WIDTH - 1) + MANTISSA_WIDTH + 2;

  cvt_state_t state, state_nxt;

  logic                      sign;
  logic [INT_WIDTH-1:0]      mag;
  logic [CW-1:0]             count;
  logic [INT_WIDTH-1:0]      in_mag;

  logic                      load_in;
  logic                      shift_en;
  logic                      load_res;

  logic [PW-1:0]             ext;
  logic [MANTISSA_WIDTH-1:0] frac_trunc;
  logic [MANTISSA_WIDTH-1:0] frac_rnd;
  logic                      guard_bit;
  logic                      sticky_bit;
  logic                      round_carry;
  logic [EXPONENT_WIDTH-1:0] exp_val;

  // Magnitude of the incoming operand; the most-negative value maps to 2^(INT_WIDTH-1)
  always_comb begin
    in_mag = in_int[INT_WIDTH-1] ? (~in_int + 1'b1) : in_int;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, handshake outputs and datapath strobes, decoded from state (and mag for NORM)
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_in   = 1'b0;
    shift_en  = 1'b0;
    load_res  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_in   = 1'b1;
          state_nxt = (in_mag == '0) ? ST_DONE : ST_NORM;
        end
      end
      ST_NORM: begin
        if (mag[INT_WIDTH-1]) begin
          state_nxt = ST_ROUND;
        end else begin
          shift_en = 1'b1;
        end
      end
      ST_ROUND: begin
        load_res  = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Split the normalised magnitude into kept fraction, guard and sticky
  always_comb begin
    ext        = {mag[INT_WIDTH-2:0], {(MANTISSA_WIDTH + 2){1'b0}}};
    frac_trunc = ext[PW-1 -: MANTISSA_WIDTH];
    guard_bit  = ext[PW-1-MANTISSA_WIDTH];
    sticky_bit = |ext[PW-2-MANTISSA_WIDTH:0];
  end

  float_round #(
    .MANTISSA_WIDTH (MANTISSA_WIDTH)
  ) u_round (
    .frac_in  (frac_trunc),
    .guard    (guard_bit),
    .sticky   (sticky_bit),
    .frac_out (frac_rnd),
    .carry    (round_carry)
  );

  // Biased exponent from the msb position; a rounding carry-out bumps it by one
  always_comb begin
    exp_val = EXPONENT_WIDTH'(BIAS + INT_WIDTH - 1) - EXPONENT_WIDTH'(count)
            + EXPONENT_WIDTH'(round_carry);
  end

  // Operand capture, normalising shift and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign      <= 1'b0;
      mag       <= '0;
      count     <= '0;
      out_float <= '0;
    end else begin
      if (load_in) begin
        sign  <= in_int[INT_WIDTH-1];
        mag   <= in_mag;
        count <= '0;
        if (in_mag == '0) begin
          out_float <= '0;
        end
      end else if (shift_en) begin
        mag   <= {mag[INT_WIDTH-2:0], 1'b0};
        count <= count + 1'b1;
      end
      if (load_res) begin
        // Carry-out leaves frac_rnd at zero, which is the required fraction
        out_float <= {sign, exp_val, frac_rnd};
      end
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Self-checking bench for int_to_float: directed cases, backpressure, mid-run reset, random.
// Latency: checks exact accept-to-valid edge count on every conversion.
// Backpressure: exercises out_ready stalls with ignored in_valid pulses.
module tb_int_to_float;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_int;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_float;

  int n_tests;
  int n_fail;

  int_to_float dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_int    (in_int),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_float (out_float)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact real-number conversion with round-half-even, from plain integer arithmetic
  function automatic logic [31:0] ref_float(input logic [31:0] v);
    logic              s;
    longint unsigned   m, q, rem, half;
    int                p, e, sh;
    if (v == 32'd0) return 32'd0;
    s = v[31];
    m = s ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
    p = 0;
    for (int i = 0; i < 64; i++) if (((m >> i) & 64'd1) != 0) p = i;
    e = 127 + p;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {s, 8'(e), q[22:0]};
  endfunction

  // Expected edges from accept to out_valid
  function automatic int ref_latency(input logic [31:0] v);
    longint unsigned m;
    int p;
    if (v == 32'd0) return 0;
    m = v[31] ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
    p = 0;
    for (int i = 0; i < 64; i++) if (((m >> i) & 64'd1) != 0) p = i;
    return (31 - p) + 2;
  endfunction

  // One full conversion: accept, wait for result, optional stall, handshake
  task automatic convert(input string tag, input logic [31:0] val,
                         input logic [31:0] exp_float, input int stall);
    int          n;
    logic [31:0] held;
    @(negedge clk);
    check({tag, ".in_ready"}, in_ready, 1'b1);
    in_int   = val;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_int   = $urandom;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, ".latency"}, n, ref_latency(val));
    check({tag, ".out_valid"}, out_valid, 1'b1);
    check({tag, ".float"}, out_float, exp_float);
    held = out_float;
    out_ready = 1'b0;
    for (int c = 0; c < stall; c++) begin
      in_valid = c[0];
      in_int   = $urandom;
      @(posedge clk);
      @(negedge clk);
      check({tag, ".stall_valid"}, out_valid, 1'b1);
      check({tag, ".stall_float"}, out_float, held);
      check({tag, ".stall_in_ready"}, in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".post_valid"}, out_valid, 1'b0);
    check({tag, ".post_in_ready"}, in_ready, 1'b1);
  endtask

  typedef struct {
    logic [31:0] val;
    logic [31:0] exp;
  } dir_t;

  initial begin
    dir_t        dirs[8];
    logic [31:0] v;
    int          k;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_int    = 32'd0;
    out_ready = 1'b0;
    #2;
    check("reset.in_ready", in_ready, 1'b1);
    check("reset.out_valid", out_valid, 1'b0);
    check("reset.out_float", out_float, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    dirs[0] = '{32'h0000_0001, 32'h3F80_0000};
    dirs[1] = '{32'hFFFF_FFFF, 32'hBF80_0000};
    dirs[2] = '{32'h0000_0000, 32'h0000_0000};
    dirs[3] = '{32'h0000_0010, 32'h4180_0000};
    dirs[4] = '{32'h7FFF_FFFF, 32'h4F00_0000};
    dirs[5] = '{32'h8000_0000, 32'hCF00_0000};
    dirs[6] = '{32'h0100_0001, 32'h4B80_0000};
    dirs[7] = '{32'h0100_0003, 32'h4B80_0002};
    for (int i = 0; i < 8; i++) begin
      convert($sformatf("dir%0d", i), dirs[i].val, dirs[i].exp, (i == 3) ? 10 : 0);
    end

    // Abort a conversion in NORM with an asynchronous reset pulse
    @(negedge clk);
    in_int   = 32'd1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort.in_ready", in_ready, 1'b1);
    check("abort.out_valid", out_valid, 1'b0);
    check("abort.out_float", out_float, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    convert("after_abort", 32'd3, 32'h4040_0000, 2);

    // Random magnitudes spread across all exponent ranges
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 31);
      v = $urandom >> k;
      if ($urandom_range(0, 1) == 1) v = -v;
      if ($urandom_range(0, 19) == 0) v = 32'd0;
      convert($sformatf("rnd%0d", i), v, ref_float(v), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
